alu_pipe: RTL and testbench

//  Parametrised, 2-stage pipelined Hack-style ALU: same zx/nx/zy/ny/f/no control semantics,

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_pipe_stage.sv | 42 ++++
 rtl/alu_pipe.sv | 120 ++++++++++++
 tb/tb_alu_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: Hack-style ALU control encoding and common op constants.
// Shared by alu_pipe (optional ALU_CARRY_EN build adds carry/ovf).
package alu_pkg;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    localparam alu_ctrl_t ALU_ZERO      = 6'b101010;
    localparam alu_ctrl_t ALU_ONE       = 6'b111111;
    localparam alu_ctrl_t ALU_X         = 6'b001100;
    localparam alu_ctrl_t ALU_ADD       = 6'b000010;
    localparam alu_ctrl_t ALU_X_MINUS_Y = 6'b010011;
    localparam alu_ctrl_t ALU_AND       = 6'b000000;

endpackage

// File: rtl/alu_pipe_stage.sv
// alu_pipe_stage: one valid/ready register slice, full throughput.
// Accepts a new beat whenever empty or when its own beat leaves.
module alu_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;
    logic         adv;

    always_comb begin
        adv     = ~valid_q | out_ready;
        valid_d = adv ? in_valid : valid_q;
        data_d  = (adv & in_valid) ? in_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: 2-stage pipelined Hack ALU with valid/ready on both sides.
// Define ALU_CARRY_EN to add registered adder carry/ovf outputs.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  alu_ctrl_t        ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
`ifdef ALU_CARRY_EN
    ,
    output logic             carry,
    output logic             ovf
`endif
);

    localparam int S1_W = 2 * WIDTH + 2;
`ifdef ALU_CARRY_EN
    localparam int S2_W = WIDTH + 4;
`else
    localparam int S2_W = WIDTH + 2;
`endif

    logic [S1_W-1:0]  s1_in;
    logic [S1_W-1:0]  s1_data;
    logic             s1_valid;
    logic             s2_ready;
    logic [S2_W-1:0]  s2_in;
    logic [S2_W-1:0]  s2_data;

    logic [WIDTH-1:0] xp;
    logic [WIDTH-1:0] yp;
    logic             fs;
    logic             ns;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] fin;

    function automatic logic [WIDTH-1:0] preset(
        input logic [WIDTH-1:0] v,
        input logic             z,
        input logic             n
    );
        logic [WIDTH-1:0] t;
        t = z ? '0 : v;
        return n ? ~t : t;
    endfunction

    always_comb begin
        s1_in = {preset(x, ctrl.zx, ctrl.nx),
                 preset(y, ctrl.zy, ctrl.ny),
                 ctrl.f, ctrl.no};
    end

    alu_pipe_stage #(.W(S1_W)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_data)
    );

    assign {xp, yp, fs, ns} = s1_data;

`ifdef ALU_CARRY_EN
    logic [WIDTH:0] sum;
    logic           co;
    logic           vo;

    // carry/ovf come from the raw adder, before the no inversion
    always_comb begin
        sum = {1'b0, xp} + {1'b0, yp};
        co  = fs & sum[WIDTH];
        vo  = fs & (xp[WIDTH-1] == yp[WIDTH-1])
                 & (sum[WIDTH-1] != xp[WIDTH-1]);
        res = fs ? sum[WIDTH-1:0] : (xp & yp);
        fin = ns ? ~res : res;
        s2_in = {fin, ~|fin, fin[WIDTH-1], co, vo};
    end
`else
    logic [WIDTH-1:0] sum;

    always_comb begin
        sum   = xp + yp;
        res   = fs ? sum : (xp & yp);
        fin   = ns ? ~res : res;
        s2_in = {fin, ~|fin, fin[WIDTH-1]};
    end
`endif

    alu_pipe_stage #(.W(S2_W)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

`ifdef ALU_CARRY_EN
    assign {out, zr, ng, carry, ovf} = s2_data;
`else
    assign {out, zr, ng} = s2_data;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe, WIDTH=16.
// Define ALU_CARRY_EN to also exercise the carry/ovf outputs.
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    alu_ctrl_t   ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        zr;
    logic        ng;
`ifdef ALU_CARRY_EN
    logic        carry;
    logic        ovf;
    logic        r_carry;
    logic        r_ovf;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] r_out;
    logic        r_zr;
    logic        r_ng;
    int          r_lat;

    alu_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zr        (zr),
        .ng        (ng)
`ifdef ALU_CARRY_EN
        ,
        .carry     (carry),
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one beat into an idle pipe, capture the result, then drain it.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input alu_ctrl_t c);
        int n;
        x = a;
        y = b;
        ctrl = c;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        r_lat = n;
        r_out = out;
        r_zr  = zr;
        r_ng  = ng;
`ifdef ALU_CARRY_EN
        r_carry = carry;
        r_ovf   = ovf;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x = '0;
        y = '0;
        ctrl = ALU_ZERO;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out !== 16'h0000) $display("FAIL rst_out: got %h want 0000", out);
        else pass_cnt++;
        total_cnt++;
        if (zr !== 1'b0) $display("FAIL rst_zr: got %b want 0", zr);
        else pass_cnt++;
        total_cnt++;
        if (ng !== 1'b0) $display("FAIL rst_ng: got %b want 0", ng);
        else pass_cnt++;
`ifdef ALU_CARRY_EN
        total_cnt++;
        if ({carry, ovf} !== 2'b00) $display("FAIL rst_cv: got %b want 00", {carry, ovf});
        else pass_cnt++;
`endif
    endtask

    task automatic test_add();
        do_op(16'd5, 16'd3, ALU_ADD);
        total_cnt++;
        if (r_lat !== 2) $display("FAIL add_latency: got %0d want 2", r_lat);
        else pass_cnt++;
        total_cnt++;
        if (r_out !== 16'h0008) $display("FAIL add_out: got %h want 0008", r_out);
        else pass_cnt++;
        total_cnt++;
        if (r_zr !== 1'b0) $display("FAIL add_zr: got %b want 0", r_zr);
        else pass_cnt++;
        total_cnt++;
        if (r_ng !== 1'b0) $display("FAIL add_ng: got %b want 0", r_ng);
        else pass_cnt++;
    endtask

    task automatic test_const();
        do_op(16'h1234, 16'hABCD, ALU_ZERO);
        total_cnt++;
        if (r_out !== 16'h0000) $display("FAIL zero_out: got %h want 0000", r_out);
        else pass_cnt++;
        total_cnt++;
        if (r_zr !== 1'b1) $display("FAIL zero_zr: got %b want 1", r_zr);
        else pass_cnt++;
        total_cnt++;
        if (r_ng !== 1'b0) $display("FAIL zero_ng: got %b want 0", r_ng);
        else pass_cnt++;
        do_op(16'h1234, 16'hABCD, ALU_ONE);
        total_cnt++;
        if (r_out !== 16'h0001) $display("FAIL one_out: got %h want 0001", r_out);
        else pass_cnt++;
        total_cnt++;
        if (r_zr !== 1'b0) $display("FAIL one_zr: got %b want 0", r_zr);
        else pass_cnt++;
    endtask

    task automatic test_sub();
        do_op(16'd3, 16'd5, ALU_X_MINUS_Y);
        total_cnt++;
        if (r_out !== 16'hFFFE) $display("FAIL sub_out: got %h want fffe", r_out);
        else pass_cnt++;
        total_cnt++;
        if (r_ng !== 1'b1) $display("FAIL sub_ng: got %b want 1", r_ng);
        else pass_cnt++;
        total_cnt++;
        if (r_zr !== 1'b0) $display("FAIL sub_zr: got %b want 0", r_zr);
        else pass_cnt++;
        do_op(16'h00F0, 16'h003C, ALU_AND);
        total_cnt++;
        if (r_out !== 16'h0030) $display("FAIL and_out: got %h want 0030", r_out);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_v [4];
        logic [15:0] held_v;
        logic        held;
        logic        saw_full;
        int          acc;
        int          del;
        int          occ;
        exp_v[0] = 16'd2;
        exp_v[1] = 16'd4;
        exp_v[2] = 16'd6;
        exp_v[3] = 16'd8;
        held = 1'b0;
        held_v = '0;
        saw_full = 1'b0;
        acc = 0;
        del = 0;
        occ = -1;
        ctrl = ALU_ADD;
        for (int cyc = 0; cyc < 40 && del < 4; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 5);
            in_valid = (acc < 4);
            x = 16'(acc + 1);
            y = 16'(acc + 1);
            #1;
            if (held) begin
                total_cnt++;
                if (out !== held_v) $display("FAIL b2b_hold: got %h want %h", out, held_v);
                else pass_cnt++;
            end
            if (!in_ready && !saw_full) begin
                saw_full = 1'b1;
                occ = acc - del;
            end
            if (out_valid && out_ready) begin
                total_cnt++;
                if (out !== exp_v[del]) $display("FAIL b2b_order: beat %0d got %h want %h", del, out, exp_v[del]);
                else pass_cnt++;
                del++;
                held = 1'b0;
            end else if (out_valid) begin
                held = 1'b1;
                held_v = out;
            end else begin
                held = 1'b0;
            end
            if (in_valid && in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total_cnt++;
        if (del !== 4) $display("FAIL b2b_count: got %0d want 4", del);
        else pass_cnt++;
        total_cnt++;
        if (saw_full !== 1'b1) $display("FAIL b2b_in_ready_drop: got %b want 1", saw_full);
        else pass_cnt++;
        total_cnt++;
        if (occ !== 2) $display("FAIL b2b_full_occ: got %0d want 2", occ);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL b2b_drained: got %b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int extra;
        out_ready = 1'b0;
        ctrl = ALU_ADD;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            x = 16'(i + 1);
            y = 16'(i + 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rmid_out_valid: got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out !== 16'h0000) $display("FAIL rmid_out: got %h want 0000", out);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL rmid_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
        do_op(16'd7, 16'd0, ALU_X);
        total_cnt++;
        if (r_out !== 16'h0007) $display("FAIL rmid_x_out: got %h want 0007", r_out);
        else pass_cnt++;
        total_cnt++;
        if (r_lat !== 2) $display("FAIL rmid_x_latency: got %0d want 2", r_lat);
        else pass_cnt++;
        extra = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) extra++;
            @(posedge clk);
            #1;
        end
        total_cnt++;
        if (extra !== 0) $display("FAIL rmid_extra_beats: got %0d want 0", extra);
        else pass_cnt++;
    endtask

`ifdef ALU_CARRY_EN
    task automatic test_carry();
        do_op(16'hFFFF, 16'h0001, ALU_ADD);
        total_cnt++;
        if ({r_out, r_zr} !== {16'h0000, 1'b1}) $display("FAIL c1_out_zr: got %h/%b want 0000/1", r_out, r_zr);
        else pass_cnt++;
        total_cnt++;
        if ({r_carry, r_ovf} !== 2'b10) $display("FAIL c1_cv: got %b want 10", {r_carry, r_ovf});
        else pass_cnt++;
        do_op(16'h7FFF, 16'h0001, ALU_ADD);
        total_cnt++;
        if ({r_out, r_ng} !== {16'h8000, 1'b1}) $display("FAIL c2_out_ng: got %h/%b want 8000/1", r_out, r_ng);
        else pass_cnt++;
        total_cnt++;
        if ({r_carry, r_ovf} !== 2'b01) $display("FAIL c2_cv: got %b want 01", {r_carry, r_ovf});
        else pass_cnt++;
        do_op(16'hFFFF, 16'h0001, ALU_AND);
        total_cnt++;
        if ({r_carry, r_ovf} !== 2'b00) $display("FAIL c3_and_cv: got %b want 00", {r_carry, r_ovf});
        else pass_cnt++;
        total_cnt++;
        if (r_out !== 16'h0001) $display("FAIL c3_and_out: got %h want 0001", r_out);
        else pass_cnt++;
        do_op(16'h7FFF, 16'h0001, ALU_AND);
        total_cnt++;
        if ({r_carry, r_ovf} !== 2'b00) $display("FAIL c4_and_cv: got %b want 00", {r_carry, r_ovf});
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_const();
        test_sub();
        test_back_to_back();
        test_reset_mid();
`ifdef ALU_CARRY_EN
        test_carry();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
